// File: rtl/debug_slave_jtag_host_if.sv
// Command/response bundle between a requester and the virtual-JTAG host.
// master: drives cmd_*, sees cmd_ready and rsp_*; slave: the host side.
interface debug_slave_jtag_host_if #(
  parameter int SR_LEN = 38
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_ir;
  logic [SR_LEN-1:0] cmd_data;
  logic              rsp_valid;
  logic [SR_LEN-1:0] rsp_data;
  logic [1:0]        rsp_ir;

  modport master (
    output cmd_valid, cmd_ir, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_ir
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_ir
  );
endinterface

// File: rtl/debug_slave_jtag_host.sv
// Virtual-JTAG host: runs UIR, CDR, SDR, UDR, RTI for one command and
// returns the shifted-out word. Ports: clk/reset, host (cmd/rsp), vji_*.
module debug_slave_jtag_host #(
  parameter int TCK_HALF   = 2,
  parameter int SR_LEN     = 38,
  parameter int RTI_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  debug_slave_jtag_host_if.slave host,
  output logic       vji_tck,
  output logic       vji_tdi,
  input  logic       vji_tdo,
  output logic [1:0] vji_ir_in,
  input  logic [1:0] vji_ir_out,
  output logic       vji_cdr,
  output logic       vji_sdr,
  output logic       vji_udr,
  output logic       vji_uir,
  output logic       vji_rti
);

  localparam int PW = $clog2(2*TCK_HALF+1);
  localparam int CW = $clog2(SR_LEN+RTI_CYCLES+1);

  typedef enum logic [2:0] {
    S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     ph_q, ph_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              tck_q, tck_d;
  logic              tdi_q, tdi_d;
  logic [1:0]        ir_in_q, ir_in_d;
  logic              uir_q, uir_d;
  logic              cdr_q, cdr_d;
  logic              sdr_q, sdr_d;
  logic              udr_q, udr_d;
  logic              rti_q, rti_d;
  logic [SR_LEN-1:0] tx_q, tx_d;
  logic [SR_LEN-1:0] rx_q, rx_d;
  logic [1:0]        ir_cap_q, ir_cap_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [SR_LEN-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]        rsp_ir_q, rsp_ir_d;
  logic              busy, rise, fall, go_resp;

  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    cnt_d       = cnt_q;
    tck_d       = tck_q;
    tdi_d       = tdi_q;
    ir_in_d     = ir_in_q;
    uir_d       = uir_q;
    cdr_d       = cdr_q;
    sdr_d       = sdr_q;
    udr_d       = udr_q;
    rti_d       = rti_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    ir_cap_d    = ir_cap_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_ir_d    = rsp_ir_q;
    rise        = 1'b0;
    fall        = 1'b0;
    go_resp     = 1'b0;
    busy        = (state_q != S_IDLE) && (state_q != S_RESP);

    // tck: low for the first half period, high for the second;
    // every state change lands on the edge that drives it low.
    if (busy) begin
      if (ph_q == PW'(2*TCK_HALF-1)) begin
        fall  = 1'b1;
        tck_d = 1'b0;
        ph_d  = '0;
      end else begin
        ph_d = ph_q + 1'b1;
        if (ph_q == PW'(TCK_HALF-1)) begin
          rise  = 1'b1;
          tck_d = 1'b1;
        end
      end
    end

    unique case (state_q)
      S_IDLE: begin
        ph_d = '0;
        if (host.cmd_valid) begin
          state_d = S_UIR;
          tx_d    = host.cmd_data;
          ir_in_d = host.cmd_ir;
          uir_d   = 1'b1;
          rti_d   = 1'b0;
        end
      end
      S_UIR: begin
        if (rise) ir_cap_d = vji_ir_out;
        if (fall) begin
          state_d = S_CDR;
          uir_d   = 1'b0;
          cdr_d   = 1'b1;
        end
      end
      S_CDR: begin
        if (fall) begin
          state_d = S_SDR;
          cdr_d   = 1'b0;
          sdr_d   = 1'b1;
          tdi_d   = tx_q[0];
          cnt_d   = '0;
        end
      end
      S_SDR: begin
        if (rise) rx_d = {vji_tdo, rx_q[SR_LEN-1:1]};
        if (fall) begin
          tx_d = tx_q >> 1;
          if (cnt_q == CW'(SR_LEN-1)) begin
            state_d = S_UDR;
            sdr_d   = 1'b0;
            udr_d   = 1'b1;
            tdi_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
            tdi_d = tx_q[1];
          end
        end
      end
      S_UDR: begin
        if (fall) begin
          udr_d = 1'b0;
          if (RTI_CYCLES == 0) begin
            go_resp = 1'b1;
          end else begin
            state_d = S_RTI;
            rti_d   = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      S_RTI: begin
        if (fall) begin
          if (cnt_q == CW'(RTI_CYCLES-1)) go_resp = 1'b1;
          else cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        rti_d   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (go_resp) begin
      state_d     = S_RESP;
      rti_d       = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_data_d  = rx_q;
      rsp_ir_d    = ir_cap_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ph_q        <= '0;
      cnt_q       <= '0;
      tck_q       <= 1'b0;
      tdi_q       <= 1'b0;
      ir_in_q     <= 2'b00;
      uir_q       <= 1'b0;
      cdr_q       <= 1'b0;
      sdr_q       <= 1'b0;
      udr_q       <= 1'b0;
      rti_q       <= 1'b1;
      tx_q        <= '0;
      rx_q        <= '0;
      ir_cap_q    <= 2'b00;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_ir_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      cnt_q       <= cnt_d;
      tck_q       <= tck_d;
      tdi_q       <= tdi_d;
      ir_in_q     <= ir_in_d;
      uir_q       <= uir_d;
      cdr_q       <= cdr_d;
      sdr_q       <= sdr_d;
      udr_q       <= udr_d;
      rti_q       <= rti_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      ir_cap_q    <= ir_cap_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ir_q    <= rsp_ir_d;
    end
  end

  assign host.cmd_ready = (state_q == S_IDLE);
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_data  = rsp_data_q;
  assign host.rsp_ir    = rsp_ir_q;
  assign vji_tck        = tck_q;
  assign vji_tdi        = tdi_q;
  assign vji_ir_in      = ir_in_q;
  assign vji_uir        = uir_q;
  assign vji_cdr        = cdr_q;
  assign vji_sdr        = sdr_q;
  assign vji_udr        = udr_q;
  assign vji_rti        = rti_q;

endmodule

// File: tb/tb_debug_slave_jtag_host.sv
// Bench for debug_slave_jtag_host: default instance plus a
// TCK_HALF=1/RTI_CYCLES=0 instance, scoreboard checked on rsp_valid.
module tb_debug_slave_jtag_host;

  localparam logic [37:0] PAT = 38'h15_5555_5555;
  localparam logic [63:0] RST_A =
    {13'd0, 1'b1, 1'b0, 38'd0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  debug_slave_jtag_host_if #(.SR_LEN(38)) ha ();
  debug_slave_jtag_host_if #(.SR_LEN(38)) hb ();

  logic a_tck, a_tdi, a_tdo, a_cdr, a_sdr, a_udr, a_uir, a_rti;
  logic [1:0] a_ir_in;
  logic [1:0] ir_out_a = 2'b11;
  logic b_tck, b_tdi, b_tdo, b_cdr, b_sdr, b_udr, b_uir, b_rti;
  logic [1:0] b_ir_in;
  logic [1:0] ir_out_b = 2'b10;

  debug_slave_jtag_host #(
    .TCK_HALF(2), .SR_LEN(38), .RTI_CYCLES(2)
  ) dut_a (
    .clk(clk), .reset(reset), .host(ha.slave),
    .vji_tck(a_tck), .vji_tdi(a_tdi), .vji_tdo(a_tdo),
    .vji_ir_in(a_ir_in), .vji_ir_out(ir_out_a),
    .vji_cdr(a_cdr), .vji_sdr(a_sdr), .vji_udr(a_udr),
    .vji_uir(a_uir), .vji_rti(a_rti)
  );

  debug_slave_jtag_host #(
    .TCK_HALF(1), .SR_LEN(38), .RTI_CYCLES(0)
  ) dut_b (
    .clk(clk), .reset(reset), .host(hb.slave),
    .vji_tck(b_tck), .vji_tdi(b_tdi), .vji_tdo(b_tdo),
    .vji_ir_in(b_ir_in), .vji_ir_out(ir_out_b),
    .vji_cdr(b_cdr), .vji_sdr(b_sdr), .vji_udr(b_udr),
    .vji_uir(b_uir), .vji_rti(b_rti)
  );

  // slave models: tck-rise loopback register, or 1/0 per SDR period
  logic mode = 1'b0;
  logic lb_a = 1'b0;
  logic alt_a = 1'b1;
  logic lb_b = 1'b0;
  always @(posedge a_tck) begin
    lb_a  <= a_tdi;
    alt_a <= a_sdr ? ~alt_a : 1'b1;
  end
  always @(posedge b_tck) lb_b <= b_tdi;
  assign a_tdo = mode ? alt_a : lb_a;
  assign b_tdo = lb_b;

  typedef struct packed {
    logic [37:0] d;
    logic [1:0]  ir;
    int          t;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int acc_a = 0, rsp_a = 0, spur_a = 0, multi_a = 0;
  int acc_b = 0, spur_b = 0, multi_b = 0;
  int cu, cc, cs, cd, cr, irbad, rti_b;
  logic [1:0] cur_ir;

  function automatic logic [63:0] outs_a();
    logic [63:0] v;
    v = {13'd0, ha.cmd_ready, ha.rsp_valid, ha.rsp_data, ha.rsp_ir,
         a_tck, a_tdi, a_ir_in, a_cdr, a_sdr, a_udr, a_uir, a_rti};
    return v;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      qa.delete();
    end else begin
      if (ha.cmd_valid && ha.cmd_ready) begin
        chk("a_one_per_idle", 64'(qa.size()), 0);
        e.d = mode ? PAT : ha.cmd_data << 1;
        e.ir = ir_out_a;
        e.t = cyc;
        qa.push_back(e);
        cur_ir = ha.cmd_ir;
        cu = 0; cc = 0; cs = 0; cd = 0; cr = 0; irbad = 0;
        acc_a++;
      end
      if (!ha.cmd_ready) begin
        cu += int'(a_uir); cc += int'(a_cdr); cs += int'(a_sdr);
        cd += int'(a_udr); cr += int'(a_rti);
        if (a_ir_in !== cur_ir) irbad++;
      end
      if ($countones({a_uir, a_cdr, a_sdr, a_udr, a_rti}) > 1)
        multi_a++;
      if (ha.rsp_valid) begin
        rsp_a++;
        if (qa.size() == 0) begin
          spur_a++;
        end else begin
          e = qa.pop_front();
          chk("a_rsp_data", 64'(ha.rsp_data), 64'(e.d));
          chk("a_rsp_ir", 64'(ha.rsp_ir), 64'(e.ir));
          chk("a_latency", 64'(cyc - 1 - e.t), 172);
          chk("a_cnt_uir", 64'(cu), 4);
          chk("a_cnt_cdr", 64'(cc), 4);
          chk("a_cnt_sdr", 64'(cs), 152);
          chk("a_cnt_udr", 64'(cd), 4);
          chk("a_cnt_rti", 64'(cr), 8);
          chk("a_ir_in_hold", 64'(irbad), 0);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      qb.delete();
    end else begin
      if (hb.cmd_valid && hb.cmd_ready) begin
        e.d = hb.cmd_data << 1;
        e.ir = ir_out_b;
        e.t = cyc;
        qb.push_back(e);
        rti_b = 0;
        acc_b++;
      end
      if (!hb.cmd_ready) rti_b += int'(b_rti);
      if ($countones({b_uir, b_cdr, b_sdr, b_udr, b_rti}) > 1)
        multi_b++;
      if (hb.rsp_valid) begin
        if (qb.size() == 0) begin
          spur_b++;
        end else begin
          e = qb.pop_front();
          chk("b_rsp_data", 64'(hb.rsp_data), 64'(e.d));
          chk("b_rsp_ir", 64'(hb.rsp_ir), 64'(e.ir));
          chk("b_latency", 64'(cyc - 1 - e.t), 82);
          chk("b_rti_low", 64'(rti_b), 0);
        end
      end
    end
  end

  task automatic send(input bit w, input logic [37:0] d,
                      input logic [1:0] ir);
    bit got;
    got = 0;
    @(posedge clk); #1;
    if (w) begin
      hb.cmd_valid = 1'b1; hb.cmd_data = d; hb.cmd_ir = ir;
    end else begin
      ha.cmd_valid = 1'b1; ha.cmd_data = d; ha.cmd_ir = ir;
    end
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ((w ? hb.cmd_ready : ha.cmd_ready) === 1'b1) begin
        got = 1;
        break;
      end
    end
    @(posedge clk); #1;
    ha.cmd_valid = 1'b0;
    hb.cmd_valid = 1'b0;
    chk(w ? "b_accept" : "a_accept", 64'(got), 1);
  endtask

  task automatic drain(input bit w);
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (w ? (qb.size() == 0 && hb.cmd_ready)
            : (qa.size() == 0 && ha.cmd_ready)) break;
    end
    chk(w ? "b_drain" : "a_drain",
        64'(w ? qb.size() : qa.size()), 0);
  endtask

  initial begin
    logic [63:0] r;
    int base;
    ha.cmd_valid = 1'b0; ha.cmd_data = '0; ha.cmd_ir = 2'b00;
    hb.cmd_valid = 1'b0; hb.cmd_data = '0; hb.cmd_ir = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("a_reset_outs", outs_a(), RST_A);
    chk("b_reset_ready_rti", 64'({hb.cmd_ready, b_rti, b_tck}), 64'b110);
    reset = 1'b0;

    // loopback on the default instance
    send(0, 38'h2A_5555_AAAA, 2'b10);
    drain(0);

    // alternating tdo pattern, slave IR status 01
    mode = 1'b1;
    ir_out_a = 2'b01;
    r = {$urandom, $urandom};
    send(0, r[37:0], 2'b11);
    drain(0);

    // cmd_valid held high with data changing every cycle
    mode = 1'b0;
    ir_out_a = 2'b10;
    base = acc_a;
    @(posedge clk); #1;
    ha.cmd_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (acc_a >= base + 3) break;
      r = {$urandom, $urandom};
      ha.cmd_data = r[37:0];
      ha.cmd_ir = 2'($urandom);
      @(posedge clk); #1;
    end
    ha.cmd_valid = 1'b0;
    chk("a_held_accepts", 64'(acc_a - base), 3);
    drain(0);

    // fast-tck, no-RTI instance
    send(1, 38'h2A_5555_AAAA, 2'b10);
    drain(1);
    r = {$urandom, $urandom};
    send(1, r[37:0], 2'b01);
    drain(1);

    // reset in the middle of shift-DR
    send(0, 38'h03_0F0F_0F0F, 2'b01);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (a_sdr) break;
    end
    chk("a_reach_sdr", 64'(a_sdr), 1);
    repeat (5) @(negedge clk);
    base = rsp_a;
    reset = 1'b1;
    @(negedge clk);
    chk("a_midrst_outs", outs_a(), RST_A);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("a_ready_after_rst", 64'(ha.cmd_ready), 1);
    repeat (250) @(negedge clk);
    chk("a_abort_no_rsp", 64'(rsp_a - base), 0);

    chk("a_spurious_rsp", 64'(spur_a), 0);
    chk("b_spurious_rsp", 64'(spur_b), 0);
    chk("a_one_hot_ind", 64'(multi_a), 0);
    chk("b_one_hot_ind", 64'(multi_b), 0);
    chk("b_accepts", 64'(acc_b), 2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
